// File: rtl/inst_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_stage
// Brief    : MIPS instruction fetch - PC register, next-PC select, IF/ID register.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        flush_in,
    input  logic        br_taken_in,
    input  logic        jump_in,
    input  logic        jr_in,
    input  logic [31:0] id_pc4_in,
    input  logic [15:0] br_offset_in,
    input  logic [27:0] jump_shift_in,
    input  logic [31:0] jr_target_in,
    output logic [31:0] imem_addr_out,
    input  logic [31:0] imem_data_in,
    input  logic        imem_ready_in,
    output logic [31:0] ins_out,
    output logic [31:0] pc4_out,
    output logic        valid_out
);

    localparam logic [31:0] c_reset_pc = {RESET_PC[31:2], 2'b00};

    logic [31:0] r_pc;
    logic [31:0] r_ins;
    logic [31:0] r_pc4;
    logic        r_valid;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_offset;
    logic [31:0] w_br_target;
    logic [31:0] w_jump_target;
    logic [31:0] w_jr_target;
    logic [31:0] w_target;
    logic [31:0] w_pc_next;
    logic        w_redirect;

    assign w_pc_plus4    = r_pc + 32'd4;
    assign w_br_offset   = {{14{br_offset_in[15]}}, br_offset_in, 2'b00};
    assign w_br_target   = id_pc4_in + w_br_offset;
    assign w_jump_target = {id_pc4_in[31:28], jump_shift_in};
    assign w_jr_target   = jr_target_in & 32'hFFFF_FFFC;
    assign w_redirect    = br_taken_in | jump_in | jr_in;

    always_comb begin
        w_target = w_br_target;
        if (jr_in) begin
            w_target = w_jr_target;
        end else if (jump_in) begin
            w_target = w_jump_target;
        end

        w_pc_next = r_pc;
        if (w_redirect) begin
            w_pc_next = w_target;
        end else if (!stall_in && imem_ready_in) begin
            w_pc_next = w_pc_plus4;
        end
        // Word alignment is enforced here so no target can misalign the PC.
        w_pc_next[1:0] = 2'b00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= c_reset_pc;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    // A redirect squashes the word fetched this cycle (no delay slot).
    always_ff @(posedge clk) begin
        if (rst || w_redirect || flush_in) begin
            r_ins   <= NOP_WORD;
            r_pc4   <= 32'd0;
            r_valid <= 1'b0;
        end else if (stall_in) begin
            r_ins   <= r_ins;
            r_pc4   <= r_pc4;
            r_valid <= r_valid;
        end else if (!imem_ready_in) begin
            r_ins   <= NOP_WORD;
            r_pc4   <= w_pc_plus4;
            r_valid <= 1'b0;
        end else begin
            r_ins   <= imem_data_in;
            r_pc4   <= w_pc_plus4;
            r_valid <= 1'b1;
        end
    end

    assign imem_addr_out = r_pc;
    assign ins_out       = r_ins;
    assign pc4_out       = r_pc4;
    assign valid_out     = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch_stage
// Brief    : Directed self-checking bench for inst_fetch_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_stage;

    localparam logic [31:0] c_nop = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        stall_in;
    logic        flush_in;
    logic        br_taken_in;
    logic        jump_in;
    logic        jr_in;
    logic [31:0] id_pc4_in;
    logic [15:0] br_offset_in;
    logic [27:0] jump_shift_in;
    logic [31:0] jr_target_in;
    logic [31:0] imem_addr_out;
    logic [31:0] imem_data_in;
    logic        imem_ready_in;
    logic [31:0] ins_out;
    logic [31:0] pc4_out;
    logic        valid_out;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] ins;
        logic [31:0] pc4;
        logic        valid;
    } exp_t;

    exp_t q_exp[$];
    int   checks;
    int   failures;

    inst_fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_WORD (c_nop)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_in      (stall_in),
        .flush_in      (flush_in),
        .br_taken_in   (br_taken_in),
        .jump_in       (jump_in),
        .jr_in         (jr_in),
        .id_pc4_in     (id_pc4_in),
        .br_offset_in  (br_offset_in),
        .jump_shift_in (jump_shift_in),
        .jr_target_in  (jr_target_in),
        .imem_addr_out (imem_addr_out),
        .imem_data_in  (imem_data_in),
        .imem_ready_in (imem_ready_in),
        .ins_out       (ins_out),
        .pc4_out       (pc4_out),
        .valid_out     (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM returns an address-tagged word so every fetch is identifiable.
    function automatic logic [31:0] tag(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign imem_data_in = tag(imem_addr_out);

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic step(input string name,
                        input logic r, input logic st, input logic fl,
                        input logic br, input logic jp, input logic jrr, input logic rdy,
                        input logic [31:0] e_addr, input logic [31:0] e_ins,
                        input logic [31:0] e_pc4, input logic e_valid);
        exp_t e;
        rst           = r;
        stall_in      = st;
        flush_in      = fl;
        br_taken_in   = br;
        jump_in       = jp;
        jr_in         = jrr;
        imem_ready_in = rdy;
        q_exp.push_back('{addr: e_addr, ins: e_ins, pc4: e_pc4, valid: e_valid});
        @(posedge clk);
        #1;
        if (q_exp.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s.scoreboard observed=empty expected=entry", name);
        end else begin
            e = q_exp.pop_front();
            chk({name, ".addr"},  imem_addr_out,     e.addr);
            chk({name, ".ins"},   ins_out,           e.ins);
            chk({name, ".pc4"},   pc4_out,           e.pc4);
            chk({name, ".valid"}, {31'd0, valid_out}, {31'd0, e.valid});
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        stall_in      = 1'b0;
        flush_in      = 1'b0;
        br_taken_in   = 1'b0;
        jump_in       = 1'b0;
        jr_in         = 1'b0;
        id_pc4_in     = 32'h0;
        br_offset_in  = 16'h0;
        jump_shift_in = 28'h0;
        jr_target_in  = 32'h0;
        imem_ready_in = 1'b1;

        //    name       rst st fl br jp jr rdy  addr          ins                 pc4           v
        step("reset0",   1, 0, 0, 0, 0, 0, 1, 32'h0000_0000, c_nop,              32'h0,        0);
        step("reset1",   1, 0, 0, 0, 0, 0, 1, 32'h0000_0000, c_nop,              32'h0,        0);
        step("run0",     0, 0, 0, 0, 0, 0, 1, 32'h0000_0004, tag(32'h0),         32'h4,        1);
        step("run4",     0, 0, 0, 0, 0, 0, 1, 32'h0000_0008, tag(32'h4),         32'h8,        1);
        step("run8",     0, 0, 0, 0, 0, 0, 1, 32'h0000_000C, tag(32'h8),         32'hC,        1);
        step("runC",     0, 0, 0, 0, 0, 0, 1, 32'h0000_0010, tag(32'hC),         32'h10,       1);
        step("stall1",   0, 1, 0, 0, 0, 0, 1, 32'h0000_0010, tag(32'hC),         32'h10,       1);
        step("stall2",   0, 1, 0, 0, 0, 0, 1, 32'h0000_0010, tag(32'hC),         32'h10,       1);
        step("stall3",   0, 1, 0, 0, 0, 0, 1, 32'h0000_0010, tag(32'hC),         32'h10,       1);
        step("resume",   0, 0, 0, 0, 0, 0, 1, 32'h0000_0014, tag(32'h10),        32'h14,       1);

        id_pc4_in    = 32'h0000_0020;
        br_offset_in = 16'hFFFE;
        step("br_stall", 0, 1, 0, 1, 0, 0, 1, 32'h0000_0018, c_nop,              32'h0,        0);
        step("after_br", 0, 0, 0, 0, 0, 0, 1, 32'h0000_001C, tag(32'h18),        32'h1C,       1);

        jump_shift_in = 28'h0000100;
        jr_target_in  = 32'h0000_0403;
        step("jr_wins",  0, 0, 0, 1, 1, 1, 1, 32'h0000_0400, c_nop,              32'h0,        0);
        step("after_jr", 0, 0, 0, 0, 0, 0, 1, 32'h0000_0404, tag(32'h400),       32'h404,      1);

        id_pc4_in = 32'h4000_0000;
        step("jump",     0, 0, 0, 0, 1, 0, 1, 32'h4000_0100, c_nop,              32'h0,        0);
        step("after_j",  0, 0, 0, 0, 0, 0, 1, 32'h4000_0104, tag(32'h4000_0100), 32'h4000_0104, 1);

        step("nrdy1",    0, 0, 0, 0, 0, 0, 0, 32'h4000_0104, c_nop,              32'h4000_0108, 0);
        step("nrdy2",    0, 0, 0, 0, 0, 0, 0, 32'h4000_0104, c_nop,              32'h4000_0108, 0);
        step("rdy_once", 0, 0, 0, 0, 0, 0, 1, 32'h4000_0108, tag(32'h4000_0104), 32'h4000_0108, 1);
        step("rdy_next", 0, 0, 0, 0, 0, 0, 1, 32'h4000_010C, tag(32'h4000_0108), 32'h4000_010C, 1);

        step("flush",    0, 0, 1, 0, 0, 0, 1, 32'h4000_0110, c_nop,              32'h0,        0);

        jr_target_in = 32'hFFFF_FFFF;
        step("jr_top",   0, 0, 0, 0, 0, 1, 1, 32'hFFFF_FFFC, c_nop,              32'h0,        0);
        step("wrap",     0, 0, 0, 0, 0, 0, 1, 32'h0000_0000, tag(32'hFFFF_FFFC), 32'h0,        1);
        step("post_wrap",0, 0, 0, 0, 0, 0, 1, 32'h0000_0004, tag(32'h0),         32'h4,        1);

        id_pc4_in    = 32'h0000_0100;
        br_offset_in = 16'h0010;
        step("br_nrdy",  0, 0, 0, 1, 0, 0, 0, 32'h0000_0140, c_nop,              32'h0,        0);
        step("after_b2", 0, 0, 0, 0, 0, 0, 1, 32'h0000_0144, tag(32'h140),       32'h144,      1);

        step("rst_mid",  1, 1, 0, 1, 0, 0, 1, 32'h0000_0000, c_nop,              32'h0,        0);
        step("post_rst", 0, 0, 0, 0, 0, 0, 1, 32'h0000_0004, tag(32'h0),         32'h4,        1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
